// File: rtl/zint_pkg.sv
// rtl/zint_pkg.sv - shared widths and IM2 vector helper for the zint interrupt controller
package zint_pkg;

  localparam int ZINT_IDX_W = 3;
  localparam int CTR_W      = 6;

  // Each source owns an even vector slot counting down from the top vector.
  function automatic logic [7:0] zint_vect(input logic [7:0] top,
                                           input logic [ZINT_IDX_W-1:0] idx);
    return top - {4'b0000, idx, 1'b0};
  endfunction

endpackage

// File: rtl/zint_prio_enc.sv
// rtl/zint_prio_enc.sv - one-hot priority winner over pending sources, search starting at ptr
module zint_prio_enc
  import zint_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0]       pend,
  input  logic [ZINT_IDX_W-1:0] ptr,
  output logic [NSRC-1:0]       win,
  output logic [ZINT_IDX_W-1:0] idx
);

  int   j;
  logic found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NSRC; k++) begin
      j = int'(ptr) + k;
      if (j >= NSRC) j = j - NSRC;
      if (!found && pend[j]) begin
        found  = 1'b1;
        win[j] = 1'b1;
        idx    = ZINT_IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/zint_mc.sv
// rtl/zint_mc.sv - Z80 IM2 interrupt controller; ZINT_RR_EN selects rotating priority
module zint_mc
  import zint_pkg::*;
#(
  parameter int              NSRC      = 4,
  parameter logic [7:0]      VECT_TOP  = 8'hFF,
  parameter int              PULSE_LEN = 32,
  parameter logic [NSRC-1:0] EXP_MASK  = 4'b0001,
  parameter logic [NSRC-1:0] DROP_MASK = 4'b0011
) (
  input  logic            clk,
  input  logic            res,
  input  logic            zpos,
  input  logic [NSRC-1:0] int_start,
  input  logic [NSRC-1:0] intmask,
  input  logic            vdos,
  input  logic            intack,
  output logic [7:0]      im2vect,
  output logic            int_n,
  output logic [NSRC-1:0] int_pend
);

  logic [NSRC-1:0]       pend_q, pend_d;
  logic                  intack_r_q, intack_r_d;
  logic [ZINT_IDX_W-1:0] sel_q, sel_d;
  logic [CTR_W-1:0]      ctr_q, ctr_d;
  logic [NSRC-1:0]       win, start_ok;
  logic [ZINT_IDX_W-1:0] win_idx, ptr;
  logic                  intack_s, ctr_fin, ack_take;

`ifdef ZINT_RR_EN
  logic [ZINT_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  assign ptr = rr_ptr_q;
`else
  assign ptr = '0;
`endif

  zint_prio_enc #(.NSRC(NSRC)) u_prio (
    .pend (pend_q),
    .ptr  (ptr),
    .win  (win),
    .idx  (win_idx)
  );

  always_comb begin
    intack_r_d = intack;
    intack_s   = intack & ~intack_r_q;
    ack_take   = intack_s & (|pend_q);
    start_ok   = int_start & ~(DROP_MASK & {NSRC{vdos}});
    ctr_fin    = (ctr_q == CTR_W'(PULSE_LEN));

    // Mask beats a new event, a new event beats the ack clearing the same source.
    for (int i = 0; i < NSRC; i++) begin
      if (!intmask[i])                pend_d[i] = 1'b0;
      else if (start_ok[i])           pend_d[i] = 1'b1;
      else if (intack_s && win[i])    pend_d[i] = 1'b0;
      else if (EXP_MASK[i] && ctr_fin) pend_d[i] = 1'b0;
      else                            pend_d[i] = pend_q[i];
    end

    if (|(start_ok & EXP_MASK))        ctr_d = '0;
    else if (zpos && !ctr_fin && !vdos) ctr_d = ctr_q + 1'b1;
    else                               ctr_d = ctr_q;

    sel_d = ack_take ? win_idx : sel_q;
`ifdef ZINT_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (ack_take)
      rr_ptr_d = (win_idx == ZINT_IDX_W'(NSRC - 1)) ? '0 : win_idx + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      pend_q     <= '0;
      intack_r_q <= 1'b0;
      sel_q      <= '0;
      ctr_q      <= CTR_W'(PULSE_LEN);
`ifdef ZINT_RR_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      pend_q     <= pend_d;
      intack_r_q <= intack_r_d;
      sel_q      <= sel_d;
      ctr_q      <= ctr_d;
`ifdef ZINT_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign int_n    = ~((|pend_q) & ~vdos);
  assign im2vect  = zint_vect(VECT_TOP, sel_q);
  assign int_pend = pend_q;

endmodule

// File: tb/tb_zint_mc.sv
// tb/tb_zint_mc.sv - self-checking bench for zint_mc: vector table, scoreboard, expiry and RR sequences
module tb_zint_mc;

  logic       clk = 1'b0;
  logic       res, zpos, vdos, intack;
  logic [3:0] int_start, intmask;
  logic [7:0] im2vect;
  logic       int_n;
  logic [3:0] int_pend;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  zint_mc dut (
    .clk       (clk),
    .res       (res),
    .zpos      (zpos),
    .int_start (int_start),
    .intmask   (intmask),
    .vdos      (vdos),
    .intack    (intack),
    .im2vect   (im2vect),
    .int_n     (int_n),
    .int_pend  (int_pend)
  );

  typedef struct {
    string      name;
    logic [3:0] start;
    logic [3:0] mask;
    logic       vd;
    logic       ack;
    logic       exp_int_n;
    logic [3:0] exp_pend;
    logic [7:0] exp_vect;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, outputs are sampled 1ns later.
  task automatic cycle(input logic [3:0] st, input logic [3:0] mk, input logic vd,
                       input logic ak, input logic zp);
    int_start = st;
    intmask   = mk;
    vdos      = vd;
    intack    = ak;
    zpos      = zp;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input string name);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_sb_vect"}, im2vect, e);
    end
  endtask

  task automatic do_reset();
    res = 1'b1;
    cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    res = 1'b0;
  endtask

  task automatic add(input string n, input logic [3:0] st, input logic [3:0] mk,
                     input logic vd, input logic ak, input logic en,
                     input logic [3:0] ep, input logic [7:0] ev);
    vec_t v;
    v.name = n; v.start = st; v.mask = mk; v.vd = vd; v.ack = ak;
    v.exp_int_n = en; v.exp_pend = ep; v.exp_vect = ev;
    vecs.push_back(v);
  endtask

  // Strobe zpos n times (zpos cycle + idle cycle each), vdos held as given.
  task automatic strobes(input int n, input logic vd);
    for (int s = 0; s < n; s++) begin
      cycle(4'h0, 4'hF, vd, 1'b0, 1'b1);
      cycle(4'h0, 4'hF, vd, 1'b0, 1'b0);
    end
  endtask

  initial begin
    res = 1'b1; zpos = 1'b0; vdos = 1'b0; intack = 1'b0;
    int_start = '0; intmask = 4'hF;

    add("t1_start",   4'b0010, 4'hF, 0, 0, 0, 4'b0010, 8'hFF);
    add("t1_ack",     4'b0000, 4'hF, 0, 1, 1, 4'b0000, 8'hFD);
    add("t1_idle",    4'b0000, 4'hF, 0, 0, 1, 4'b0000, 8'hFD);
    add("t2_start02", 4'b0101, 4'hF, 0, 0, 0, 4'b0101, 8'hFD);
    add("t2_ack1",    4'b0000, 4'hF, 0, 1, 0, 4'b0100, 8'hFF);
    add("t2_hold",    4'b0000, 4'hF, 0, 0, 0, 4'b0100, 8'hFF);
    add("t2_ack2",    4'b0000, 4'hF, 0, 1, 1, 4'b0000, 8'hFB);
    add("t2_idle",    4'b0000, 4'hF, 0, 0, 1, 4'b0000, 8'hFB);
    add("t3_vdos",    4'b0110, 4'hF, 1, 0, 1, 4'b0100, 8'hFB);
    add("t3_vdos_lo", 4'b0000, 4'hF, 0, 0, 0, 4'b0100, 8'hFB);
    add("t3_ack",     4'b0000, 4'hF, 0, 1, 1, 4'b0000, 8'hFB);
    add("t3_idle",    4'b0000, 4'hF, 0, 0, 1, 4'b0000, 8'hFB);
    add("t4_start3",  4'b1000, 4'hF, 0, 0, 0, 4'b1000, 8'hFB);
    add("t4_mask",    4'b0000, 4'h7, 0, 0, 1, 4'b0000, 8'hFB);
    add("t4_restart", 4'b1000, 4'hF, 0, 0, 0, 4'b1000, 8'hFB);
    add("t4_st_ack",  4'b1000, 4'hF, 0, 1, 0, 4'b1000, 8'hF9);
    add("t4_hold",    4'b0000, 4'hF, 0, 0, 0, 4'b1000, 8'hF9);
    add("t4_ack",     4'b0000, 4'hF, 0, 1, 1, 4'b0000, 8'hF9);
    add("t4_idle",    4'b0000, 4'hF, 0, 0, 1, 4'b0000, 8'hF9);
    add("t4_mask_st", 4'b1000, 4'h7, 0, 0, 1, 4'b0000, 8'hF9);
    add("t4_unmask",  4'b0000, 4'hF, 0, 0, 1, 4'b0000, 8'hF9);

    do_reset();
    chk("reset_int_n", int_n, 1'b1);
    chk("reset_pend", int_pend, 4'b0000);
    chk("reset_vect", im2vect, 8'hFF);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ack && !intack) sb_q.push_back(vecs[i].exp_vect);
      cycle(vecs[i].start, vecs[i].mask, vecs[i].vd, vecs[i].ack, 1'b0);
      chk({vecs[i].name, "_int_n"}, int_n, vecs[i].exp_int_n);
      chk({vecs[i].name, "_pend"}, int_pend, vecs[i].exp_pend);
      chk({vecs[i].name, "_vect"}, im2vect, vecs[i].exp_vect);
      if (vecs[i].ack && sb_q.size() != 0) sb_pop(vecs[i].name);
    end

    // Expiry: source 0 clears on the clk after the 32nd counted zpos.
    do_reset();
    cycle(4'b0001, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("exp_start", int_pend, 4'b0001);
    strobes(31, 1'b0);
    chk("exp_31", int_pend, 4'b0001);
    cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b1);
    chk("exp_32_edge", int_pend, 4'b0001);
    cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("exp_32_clear", int_pend, 4'b0000);
    chk("exp_int_n", int_n, 1'b1);

    // Expiry with 10 strobes under vdos: clear slips by 10 strobes.
    cycle(4'b0001, 4'hF, 1'b0, 1'b0, 1'b0);
    strobes(4, 1'b0);
    strobes(10, 1'b1);
    chk("expv_frozen_int_n", int_n, 1'b1);
    strobes(27, 1'b0);
    chk("expv_41", int_pend, 4'b0001);
    cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b1);
    cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("expv_42_clear", int_pend, 4'b0000);

    // Mid-operation reset drops pending and restores the top vector.
    cycle(4'b0100, 4'hF, 1'b0, 1'b0, 1'b0);
    cycle(4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
    chk("mid_vect_pre", im2vect, 8'hFB);
    cycle(4'b0010, 4'hF, 1'b0, 1'b0, 1'b0);
    res = 1'b1;
    cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
    res = 1'b0;
    chk("mid_reset_pend", int_pend, 4'b0000);
    chk("mid_reset_vect", im2vect, 8'hFF);
    chk("mid_reset_int_n", int_n, 1'b1);

`ifdef ZINT_RR_EN
    do_reset();
    begin
      logic [7:0] rr_exp[3];
      rr_exp[0] = 8'hFF; rr_exp[1] = 8'hFD; rr_exp[2] = 8'hFF;
      cycle(4'b0011, 4'hF, 1'b0, 1'b0, 1'b0);
      for (int a = 0; a < 3; a++) begin
        sb_q.push_back(rr_exp[a]);
        cycle(4'b0011, 4'hF, 1'b0, 1'b1, 1'b0);
        sb_pop("rr_ack");
        cycle(4'b0011, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("rr_pend", int_pend, 4'b0011);
      end
    end
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
